// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types, default widths and payload field offsets
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    HALT  = 2'd3
  } pipe_state_t;

  // Payload layout, LSB first: result | target | control | destination
  localparam int PIPE_RES_LSB   = 0;
  localparam int PIPE_RES_W     = 16;
  localparam int PIPE_TGT_LSB   = PIPE_RES_LSB + PIPE_RES_W;
  localparam int PIPE_TGT_W     = 16;
  localparam int PIPE_CTRL_LSB  = PIPE_TGT_LSB + PIPE_TGT_W;
  localparam int PIPE_CTRL_W    = 8;
  localparam int PIPE_DEST_LSB  = PIPE_CTRL_LSB + PIPE_CTRL_W;
  localparam int PIPE_DEST_W    = 5;

  localparam int PIPE_PAYLOAD_W = PIPE_DEST_LSB + PIPE_DEST_W;
  localparam int PIPE_CNT_W     = 16;

  function automatic logic [PIPE_PAYLOAD_W-1:0] pack_payload(
    input logic [PIPE_DEST_W-1:0] dest,
    input logic [PIPE_CTRL_W-1:0] ctrl,
    input logic [PIPE_TGT_W-1:0]  target,
    input logic [PIPE_RES_W-1:0]  result
  );
    logic [PIPE_PAYLOAD_W-1:0] p;
    p = '0;
    p[PIPE_DEST_LSB +: PIPE_DEST_W] = dest;
    p[PIPE_CTRL_LSB +: PIPE_CTRL_W] = ctrl;
    p[PIPE_TGT_LSB  +: PIPE_TGT_W]  = target;
    p[PIPE_RES_LSB  +: PIPE_RES_W]  = result;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready beat channel between pipeline stages
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W
);

  logic                 valid;
  logic                 ready;
  logic                 halt;
  logic [PAYLOAD_W-1:0] data;

  modport master (output valid, output halt, output data, input ready);
  modport slave  (input valid, input halt, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - enable-driven up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic pipeline stage register with flush, halt freeze and stall counter
// PIPE_STAGE_SKID_EN adds a second (skid) entry and makes in_ready independent of out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int CNT_W     = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             resume,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t          state_q;
  pipe_state_t          state_d;
  logic [PAYLOAD_W-1:0] out_data_q;

  logic in_ready_w;
  logic out_valid_w;
  logic in_xfer;
  logic out_xfer;
  logic ld_in_out;
  logic clr;

`ifdef PIPE_STAGE_SKID_EN
  logic [PAYLOAD_W-1:0] skid_data_q;
  logic                 skid_halt_q;
  logic                 skid_valid_q;
  logic                 ld_in_skid;
  logic                 ld_skid_out;
`endif

  assign out_valid_w = (state_q != EMPTY);
  assign halted      = (state_q == HALT);

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready_w  = ((state_q == EMPTY) || (state_q == ONE)) && !halted;
`else
  assign in_ready_w  = !halted && (!out_valid_w || out_if.ready);
`endif

  assign in_xfer  = in_if.valid && in_ready_w;
  assign out_xfer = out_valid_w && out_if.ready && !halted;

  assign in_if.ready  = in_ready_w;
  assign out_if.valid = out_valid_w;
  assign out_if.halt  = halted;
  assign out_if.data  = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // HALT outranks flush; a beat reaching the output register with halt set freezes the stage
  always_comb begin
    state_d   = state_q;
    ld_in_out = 1'b0;
    clr       = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    ld_in_skid  = 1'b0;
    ld_skid_out = 1'b0;
`endif
    unique case (state_q)
      EMPTY: begin
        if (flush) begin
          clr = 1'b1;
        end else if (in_xfer) begin
          ld_in_out = 1'b1;
          state_d   = in_if.halt ? HALT : ONE;
        end
      end
      ONE: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = EMPTY;
        end else if (out_xfer && in_xfer) begin
          ld_in_out = 1'b1;
          state_d   = in_if.halt ? HALT : ONE;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
`ifdef PIPE_STAGE_SKID_EN
        else if (in_xfer) begin
          ld_in_skid = 1'b1;
          state_d    = TWO;
        end
`endif
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        if (flush) begin
          clr     = 1'b1;
          state_d = EMPTY;
        end else if (out_xfer) begin
          ld_skid_out = 1'b1;
          state_d     = skid_halt_q ? HALT : ONE;
        end
      end
`endif
      HALT: begin
        if (resume) begin
`ifdef PIPE_STAGE_SKID_EN
          if (skid_valid_q) begin
            ld_skid_out = 1'b1;
            state_d     = skid_halt_q ? HALT : ONE;
          end else
`endif
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q  <= '0;
      skid_halt_q  <= 1'b0;
      skid_valid_q <= 1'b0;
`endif
    end else if (clr) begin
      out_data_q   <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_q <= 1'b0;
`endif
    end else begin
      if (ld_in_out) begin
        out_data_q <= in_if.data;
      end
`ifdef PIPE_STAGE_SKID_EN
      if (ld_skid_out) begin
        out_data_q   <= skid_data_q;
        skid_valid_q <= 1'b0;
      end
      if (ld_in_skid) begin
        skid_data_q  <= in_if.data;
        skid_halt_q  <= in_if.halt;
        skid_valid_q <= 1'b1;
      end
`endif
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (out_valid_w && !out_if.ready && !halted),
    .cnt   (stall_cnt)
  );

endmodule
